// File: rtl/fetch_queue.sv
// Instruction-fetch front end: issues sequential word fetches, buffers responses
// in a circular queue and hands {pc, data} to decode in order; redirects flush.
module fetch_queue #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          DEPTH    = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic        redirect,
  input  logic [31:0] redirect_pc,
  output logic        imem_req_valid,
  input  logic        imem_req_ready,
  output logic [31:0] imem_req_addr,
  input  logic        imem_resp_valid,
  input  logic [31:0] imem_resp_data,
  output logic        inst_valid,
  input  logic        inst_ready,
  output logic [31:0] inst_pc,
  output logic [31:0] inst_data
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;
  localparam logic [CNT_W:0] DEPTH_C = (CNT_W + 1)'(DEPTH);

  logic [31:0]      fetch_pc_q, fetch_pc_d;
  logic [PTR_W-1:0] alloc_ptr_q, alloc_ptr_d;
  logic [PTR_W-1:0] fill_ptr_q, fill_ptr_d;
  logic [PTR_W-1:0] head_ptr_q, head_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic [CNT_W-1:0] pend_q, pend_d;
  logic [CNT_W-1:0] drop_cnt_q, drop_cnt_d;
  logic [DEPTH-1:0] filled_q, filled_d;
  logic [31:0]      pc_q   [DEPTH];
  logic [31:0]      pc_d   [DEPTH];
  logic [31:0]      data_q [DEPTH];
  logic [31:0]      data_d [DEPTH];

  logic [CNT_W:0] credit_used;
  logic           req_fire;
  logic           pop;
  logic           resp_fill;
  logic           resp_drop;

  // Handshakes: a transfer happens in any cycle where valid && ready are both
  // high; valid never depends on ready, and the request stays stable until taken.
  // Credit covers both live entries and responses still owed for flushed work.
  assign credit_used    = {1'b0, count_q} + {1'b0, drop_cnt_q};
  assign imem_req_valid = rst_n && !redirect && (credit_used < DEPTH_C);
  assign imem_req_addr  = fetch_pc_q;
  assign inst_valid     = rst_n && !redirect && (count_q != '0) && filled_q[head_ptr_q];
  assign inst_pc        = pc_q[head_ptr_q];
  assign inst_data      = data_q[head_ptr_q];

  assign req_fire  = imem_req_valid && imem_req_ready;
  assign pop       = inst_valid && inst_ready;
  assign resp_drop = imem_resp_valid && (drop_cnt_q != '0);
  assign resp_fill = imem_resp_valid && (drop_cnt_q == '0);

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    alloc_ptr_d = alloc_ptr_q;
    fill_ptr_d  = fill_ptr_q;
    head_ptr_d  = head_ptr_q;
    count_d     = count_q;
    pend_d      = pend_q;
    drop_cnt_d  = drop_cnt_q;
    filled_d    = filled_q;
    pc_d        = pc_q;
    data_d      = data_q;
    if (redirect) begin
      // Every still-unfilled entry becomes a response to discard; a response
      // landing this same cycle settles one of those debts immediately.
      fetch_pc_d  = redirect_pc & 32'hFFFF_FFFC;
      alloc_ptr_d = '0;
      fill_ptr_d  = '0;
      head_ptr_d  = '0;
      count_d     = '0;
      pend_d      = '0;
      drop_cnt_d  = drop_cnt_q + pend_q - CNT_W'(imem_resp_valid);
    end else begin
      if (req_fire) begin
        pc_d[alloc_ptr_q]     = fetch_pc_q;
        filled_d[alloc_ptr_q] = 1'b0;
        alloc_ptr_d           = alloc_ptr_q + 1'b1;
        fetch_pc_d            = fetch_pc_q + 32'd4;
      end
      if (resp_fill) begin
        data_d[fill_ptr_q]   = imem_resp_data;
        filled_d[fill_ptr_q] = 1'b1;
        fill_ptr_d           = fill_ptr_q + 1'b1;
      end
      if (resp_drop) begin
        drop_cnt_d = drop_cnt_q - 1'b1;
      end
      if (pop) begin
        head_ptr_d = head_ptr_q + 1'b1;
      end
      count_d = count_q + CNT_W'(req_fire) - CNT_W'(pop);
      pend_d  = pend_q + CNT_W'(req_fire) - CNT_W'(resp_fill);
    end
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      fetch_pc_q  <= RESET_PC;
      alloc_ptr_q <= '0;
      fill_ptr_q  <= '0;
      head_ptr_q  <= '0;
      count_q     <= '0;
      pend_q      <= '0;
      drop_cnt_q  <= '0;
      filled_q    <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      alloc_ptr_q <= alloc_ptr_d;
      fill_ptr_q  <= fill_ptr_d;
      head_ptr_q  <= head_ptr_d;
      count_q     <= count_d;
      pend_q      <= pend_d;
      drop_cnt_q  <= drop_cnt_d;
      filled_q    <= filled_d;
    end
  end

  // Payload storage needs no reset; filled_q and count_q qualify it.
  always_ff @(posedge clk) begin
    pc_q   <= pc_d;
    data_q <= data_d;
  end

endmodule

// File: doc/fetch_queue.md
# fetch_queue

Instruction-fetch front end that consumes the program-counter stream and turns it into instruction-memory requests. It returns fetched instructions, paired with their PCs, to decode in program order. It owns the sequential fetch address and holds up to DEPTH in-flight or buffered fetches. On a branch/jump redirect it flushes all younger work, including responses still in flight from memory.

## Interface
- RESET_PC, 32'h0000_0000, fetch address after reset
- DEPTH, 4, queue entries (power of two, 2..16); bounds allocated + to-be-dropped fetches
- clk  input  1  clock, all state updates on posedge
- rst_n  input  1  synchronous, active-low reset
- redirect  input  1  taken branch/jump; flush and restart at redirect_pc
- redirect_pc  input  32  new fetch address; bits [1:0] ignored (treated as 0)
- imem_req_valid  output  1  fetch request valid
- imem_req_ready  input  1  memory accepts request
- imem_req_addr  output  32  fetch address, word aligned
- imem_resp_valid  input  1  one response, strictly in request order, latency >= 1 cycle
- imem_resp_data  input  32  instruction word
- inst_valid  output  1  head instruction available to decode
- inst_ready  input  1  decode consumes head
- inst_pc  output  32  PC of head instruction
- inst_data  output  32  head instruction word

## Operation
- State: fetch_pc (32), circular queue of DEPTH entries {pc, data, filled}, alloc pointer (write), fill pointer, head pointer, count (allocated entries), drop_cnt (responses to discard, 0..DEPTH).
- Request: imem_req_valid = rst_n && !redirect && (count + drop_cnt < DEPTH); imem_req_addr = fetch_pc.
- Request handshake (valid && ready): allocate entry at alloc pointer with pc = fetch_pc and filled = 0; fetch_pc += 4 (wraps modulo 2^32); count++.
- Response with drop_cnt > 0: discard the data; drop_cnt--.
- Response with drop_cnt = 0: write data into the entry at the fill pointer; set filled = 1; advance the fill pointer.
- Pop: inst_valid = !redirect && count > 0 && head.filled. Outputs show the head entry. On inst_valid && inst_ready, free the head and decrement count.
- Same-cycle allocate + pop: count unchanged. Allocate, fill and pop may all occur in one cycle on distinct entries.
- Redirect (priority over everything):
  - fetch_pc <= {redirect_pc[31:2], 2'b00}.
  - All entries freed; count = 0; pointers reset to a common value.
  - drop_cnt <= drop_cnt + (unfilled allocated entries) − (imem_resp_valid in that cycle).
  - No request handshake and no pop in the redirect cycle.
- Back-to-back redirects accumulate drop_cnt correctly; drop_cnt never exceeds DEPTH.
- Requests resume while drop_cnt > 0. Memory ordering guarantees the dropped responses arrive first.
- Reset (any cycle, including mid-flight):
  - fetch_pc = RESET_PC; count = 0; drop_cnt = 0; all pointers 0.
  - Outputs during reset: imem_req_valid = 0, inst_valid = 0.
  - imem_req_addr, inst_pc and inst_data are don't-care but must not be X-propagating into valid.
  - The environment must not deliver responses to pre-reset requests after reset.

## Timing
- First cycle with rst_n = 1: imem_req_valid = 1, imem_req_addr = RESET_PC.
- Sustained throughput: 1 request/cycle and 1 instruction/cycle while the queue is not full and ready signals are high.
- Response to inst_valid: 1 cycle. A response in cycle N makes the entry visible at N+1 if it is the head; there is no bypass.
- Redirect asserted in cycle N: imem_req_valid = 1 with addr = redirect_pc at N+1 (if credit allows). inst_valid = 0 in cycle N.
- Full condition: count + drop_cnt = DEPTH deasserts imem_req_valid in the same cycle. It reasserts the cycle after a pop or a dropped response frees credit.
- imem_req_addr and imem_req_valid must be held stable while valid && !ready.

## Test plan
- Reset release, mem latency 1, inst_ready = 1 -> requests 0x0, 0x4, 0x8, … on consecutive cycles. inst_pc/inst_data pairs emerge in order, 2 cycles after each request.
- inst_ready = 0, DEPTH = 4, latency 1 -> exactly 4 requests (0x0–0xC), then imem_req_valid = 0. Raising inst_ready pops 0x0 and request 0x10 issues the next cycle.
- Redirect to 0x100 with 3 requests outstanding, latency 5 -> next request addr 0x100, and the 3 stale responses are discarded. First inst_pc = 0x100 with its own data; drop_cnt returns to 0.
- Redirect in the same cycle as a response, with 2 unfilled entries -> drop_cnt = 1 and only one later response is discarded. Also redirect_pc = 0x203 -> fetch at 0x200.
- fetch_pc = 0xFFFF_FFFC -> next request addr 0x0000_0000 (wrap). imem_req_ready toggling -> address held stable, no duplicated or skipped PCs.
- rst_n low mid-stream with a full queue -> next cycle inst_valid = 0 and imem_req_valid = 0. After release, fetch restarts at RESET_PC.
